// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-memory port between NUM_REQ requesters,
// with bounded burst lock and per-owner routing of 1-cycle-latency read data.

module mem_port_lane #(
    parameter int ID  = 0,
    parameter int IDW = 2
) (
    input  logic [31:0]    addr,
    input  logic           own_vld,
    input  logic [IDW-1:0] own_id,
    output logic           mis,
    output logic           hit
);
    assign mis = |addr[1:0];
    assign hit = own_vld && (own_id == IDW'(ID));
endmodule

module mem_port_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_we,
    input  logic [NUM_REQ-1:0]      req_lock,
    input  logic [32*NUM_REQ-1:0]   req_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic [NUM_REQ-1:0]      wr_err,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_din,
    output logic                    mem_re,
    output logic                    mem_we,
    input  logic [31:0]             mem_dout
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic          vld;
        logic [PW-1:0] id;
        logic          err;
    } rd_own_t;

    logic [NUM_REQ-1:0][31:0] addr_a;
    logic [NUM_REQ-1:0][31:0] wdata_a;
    logic [NUM_REQ-1:0]       mis;
    logic [NUM_REQ-1:0]       gnt;
    logic [PW-1:0]            gid;
    logic                     any;
    logic [PW-1:0]            ptr_q;
    logic [3:0]               cnt_q;
    logic [31:0]              last_addr_q;
    logic [31:0]              last_din_q;
    rd_own_t                  own_q;
    logic [31:0]              addr_w;
    logic [31:0]              wdata_w;
    logic                     we_w;
    logic [PW-1:0]            gid_next;
    logic                     keep_lock;

    assign addr_a  = req_addr;
    assign wdata_a = req_wdata;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        mem_port_lane #(.ID(i), .IDW(PW)) u_lane (
            .addr    (addr_a[i]),
            .own_vld (own_q.vld),
            .own_id  (own_q.id),
            .mis     (mis[i]),
            .hit     (rsp_valid[i])
        );
    end

    // Scan from the pointer, wrapping, and take the first valid requester.
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        gid = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req_valid[j]) begin
                any    = 1'b1;
                gid    = PW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

    assign req_ready = gnt;
    assign addr_w    = addr_a[gid];
    assign wdata_w   = wdata_a[gid];
    assign we_w      = req_we[gid];

    assign mem_addr  = any ? {addr_w[31:2], 2'b00} : last_addr_q;
    assign mem_din   = any ? wdata_w : last_din_q;
    assign mem_we    = any & we_w;
    assign mem_re    = any & ~we_w;

    assign rsp_rdata = mem_dout;
    assign rsp_err   = own_q.vld & own_q.err;

    assign gid_next  = (gid == PW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
    assign keep_lock = req_lock[gid] && (({1'b0, cnt_q} + 5'd1) < 5'(MAX_BURST));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            last_addr_q <= '0;
            last_din_q  <= '0;
            own_q       <= '0;
            wr_err      <= '0;
        end else begin
            own_q.vld <= any & ~we_w;
            own_q.id  <= gid;
            own_q.err <= mis[gid];
            wr_err    <= (any && we_w && mis[gid]) ? gnt : '0;
            if (any) begin
                last_addr_q <= {addr_w[31:2], 2'b00};
                last_din_q  <= wdata_w;
                if (keep_lock) begin
                    ptr_q <= gid;
                    cnt_q <= cnt_q + 4'd1;
                end else begin
                    ptr_q <= gid_next;
                    cnt_q <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small registered-read word memory.

module tb_mem_port_arbiter;
    localparam int N = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid, req_ready, req_we, req_lock;
    logic [N-1:0][31:0] req_addr, req_wdata;
    logic [N-1:0]      rsp_valid, wr_err;
    logic [31:0]       rsp_rdata, mem_addr, mem_din, mem_dout;
    logic              rsp_err, mem_re, mem_we;

    logic [31:0] mem [0:63];
    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.NUM_REQ(N), .MAX_BURST(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wr_err(wr_err), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_re(mem_re), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_din;
        if (mem_re) mem_dout <= mem[mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        req_valid = '0; req_we = '0; req_lock = '0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
        mem_dout = '0;
        reset_n = 1'b0;
        idle();
        req_addr = '0; req_wdata = '0;

        // reset state
        @(negedge clock); #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_wr_err", 32'(wr_err), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_mem_re_we", 32'({mem_re, mem_we}), 32'h0);
        @(negedge clock); reset_n = 1'b1;

        // all valid reads, no lock: rotate 0,1,2,0,1,2
        req_addr[0] = 32'h04; req_addr[1] = 32'h08; req_addr[2] = 32'h0C;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            req_valid = (c < 6) ? 3'b111 : 3'b000;
            #1;
            chk("rr_ready", 32'(req_ready), (c < 6) ? 32'(1 << (c % 3)) : 32'h0);
            if (c < 6) chk("rr_mem_addr", mem_addr, 32'h04 + 32'(4 * (c % 3)));
            chk("rr_rsp_valid", 32'(rsp_valid), (c > 0) ? 32'(1 << ((c - 1) % 3)) : 32'h0);
            if (c > 0) chk("rr_rdata", rsp_rdata, 32'h1000_0001 + 32'((c - 1) % 3));
        end

        // requester 1 writes 0x40, requester 2 reads it back
        @(negedge clock);
        req_valid = 3'b010; req_we = 3'b010;
        req_addr[1] = 32'h40; req_wdata[1] = 32'hDEADBEEF;
        #1;
        chk("wr_ready", 32'(req_ready), 32'h2);
        chk("wr_mem_we", 32'({mem_we, mem_re}), 32'h2);
        chk("wr_mem_addr", mem_addr, 32'h40);
        chk("wr_mem_din", mem_din, 32'hDEADBEEF);
        @(negedge clock);
        req_valid = 3'b100; req_we = 3'b000; req_addr[2] = 32'h40;
        #1;
        chk("rd40_ready", 32'(req_ready), 32'h4);
        chk("rd40_mem_re", 32'(mem_re), 32'h1);
        chk("rd40_no_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clock);
        idle(); #1;
        chk("rd40_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("rd40_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd40_rsp_err", 32'(rsp_err), 32'h0);
        chk("idle_hold_addr", mem_addr, 32'h40);
        chk("idle_no_re", 32'({mem_re, mem_we}), 32'h0);

        // burst lock: grants 0,0,0,0,1
        req_addr[0] = 32'h04; req_addr[1] = 32'h08;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            req_valid = 3'b011; req_lock = 3'b001;
            #1;
            chk("lock_ready", 32'(req_ready), (c < 4) ? 32'h1 : 32'h2);
        end
        @(negedge clock); idle();

        // misaligned read by 2, misaligned write by 1
        @(negedge clock);
        req_valid = 3'b100; req_addr[2] = 32'h43;
        #1;
        chk("mis_rd_ready", 32'(req_ready), 32'h4);
        chk("mis_rd_addr", mem_addr, 32'h40);
        @(negedge clock);
        req_valid = 3'b010; req_we = 3'b010;
        req_addr[1] = 32'h41; req_wdata[1] = 32'h1234_5678;
        #1;
        chk("mis_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("mis_rsp_err", 32'(rsp_err), 32'h1);
        chk("mis_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("mis_wr_ready", 32'(req_ready), 32'h2);
        chk("mis_wr_addr", mem_addr, 32'h40);
        chk("mis_wr_we", 32'(mem_we), 32'h1);
        chk("mis_wr_err_early", 32'(wr_err), 32'h0);
        @(negedge clock);
        idle(); #1;
        chk("mis_wr_err", 32'(wr_err), 32'h2);
        chk("mis_rsp_clear", 32'({rsp_valid, rsp_err}), 32'h0);
        @(negedge clock); #1;
        chk("mis_wr_err_pulse", 32'(wr_err), 32'h0);
        chk("mis_wr_mem", mem[16], 32'h1234_5678);

        // reset right after a read accept
        @(negedge clock);
        req_valid = 3'b001; req_addr[0] = 32'h04;
        #1;
        chk("pre_rst_ready", 32'(req_ready), 32'h1);
        @(negedge clock);
        idle(); reset_n = 1'b0;
        #1;
        chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clock); #1;
        chk("mid_rst_rsp2", 32'(rsp_valid), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        req_valid = 3'b111; req_we = 3'b000;
        req_addr[0] = 32'h04; req_addr[1] = 32'h08; req_addr[2] = 32'h0C;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clock);
        idle(); #1;
        chk("post_rst_rsp", 32'(rsp_valid), 32'h1);
        chk("post_rst_rdata", rsp_rdata, 32'h1000_0001);

        // only requester 2, streaming reads
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            req_valid = (c < 4) ? 3'b100 : 3'b000;
            req_addr[2] = 32'h0C + 32'(4 * c);
            #1;
            chk("r2_ready", 32'(req_ready), (c < 4) ? 32'h4 : 32'h0);
            chk("r2_rsp_valid", 32'(rsp_valid), (c > 0) ? 32'h4 : 32'h0);
            if (c > 0) chk("r2_rdata", rsp_rdata, 32'h1000_0002 + 32'(c));
        end

        @(negedge clock); idle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one port of the dual-port word memory (addr/din/dout/re/we, registered read, 1-cycle latency) between NUM_REQ requesters, e.g. instruction fetch, load/store unit and sprite/framebuffer reader.
- Uses round-robin arbitration with optional bounded burst lock.
- Routes each read response back to its originator.
- One instance sits in front of each memory port.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_BURST, 4, maximum consecutive grants to one locked requester before priority is forced onward (1..15).

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  request to keep the grant for the next beat.
- req_addr  in  32*NUM_REQ  byte address; requester i is bits [32i+31:32i].
- req_wdata  in  32*NUM_REQ  write data, same packing.
- rsp_valid  out  NUM_REQ  read data valid for requester i.
- rsp_rdata  out  32  read data, shared by all requesters, qualified by rsp_valid.
- rsp_err  out  1  accompanies rsp_valid; the request was misaligned.
- wr_err  out  NUM_REQ  one-cycle pulse on acceptance of a misaligned write.
- mem_addr  out  32  to memory addr_x.
- mem_din  out  32  to memory din_x.
- mem_re  out  1  to memory re_x.
- mem_we  out  1  to memory we_x.
- mem_dout  in  32  from memory dout_x.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid, wr_err, rsp_err = 0.
  - Priority pointer = 0; burst count = 0.
  - Registered read-owner valid = 0.
- Grant is combinational:
  - Among req_valid bits, pick the first at or after the pointer (pointer first, wrapping modulo NUM_REQ).
  - req_ready[g] = 1 only for the winner, in the same cycle. Acceptance = req_valid & req_ready.
  - The arbiter is never stalled, so one request can be accepted every cycle.
- Memory drive (combinational from the winner):
  - mem_addr = {req_addr[31:2], 2'b00}. Addresses are aligned down, because words live at 4-byte-aligned indices.
  - mem_din = winner wdata; mem_we = accept & we; mem_re = accept & ~we.
  - With no winner: mem_re = mem_we = 0, and mem_addr/mem_din hold the last value.
- Read response:
  - On a read accept, register owner id, valid and misalignment flag (addr[1:0] != 0).
  - Next cycle: rsp_valid[owner] = 1, rsp_rdata = mem_dout, rsp_err = flag.
  - Exactly one response per accepted read, in order, with 1-cycle latency.
  - Back-to-back reads from different requesters give back-to-back responses to the correct owners.
- Write: completes on acceptance; no rsp_valid. Misaligned write: still performed at the aligned address, and wr_err[g] pulses the following cycle.
- Pointer update on each accept by requester g:
  - If req_lock[g] = 1 and burst count + 1 < MAX_BURST: pointer stays at g and burst count increments.
  - Otherwise pointer = (g+1) mod NUM_REQ and burst count = 0.
  - No accept: pointer and count are held.
  - A locked requester that drops req_valid loses priority naturally, because the next valid requester wins; the count then resets on that requester's accept.
- Simultaneous events:
  - A read response for a prior request and a new accept in the same cycle are independent.
  - When all requesters are valid and none lock, grants rotate 0,1,2,0,...
- Reset mid-operation: an in-flight read is dropped and no rsp_valid is issued after reset; the pointer returns to 0.
- Width rule: pointer is $clog2(NUM_REQ) bits with explicit wrap, so the pointer never exceeds NUM_REQ-1. Burst counter is 4 bits.

Test Plan:
- Reset, then req_valid=3'b111, all reads, no lock, for 6 cycles -> grants 0,1,2,0,1,2; each rsp_valid one-hot one cycle after its grant with the correct mem_dout word.
- Requester 1 writes 0xDEADBEEF to 0x40, then requester 2 reads 0x40 -> rsp_valid=3'b100 two cycles after the write accept; rsp_rdata=0xDEADBEEF; rsp_err=0.
- Requester 0 holds valid and lock with MAX_BURST=4 while requester 1 is valid -> grants 0,0,0,0,1; no requester is starved.
- Requester 2 reads 0x43 -> mem_addr=0x40; rsp_err=1 alongside rsp_valid[2]. Requester 1 writes 0x41 -> mem_we at 0x40, and wr_err[1] pulses the next cycle.
- Assert reset_n=0 the cycle after a read accept -> rsp_valid stays 0; after release, the first grant goes to requester 0 when all are valid.
- Only requester 2 is valid, continuously, without lock -> accepted every cycle; pointer wraps from 2 to 0 each time; one response per read with no gaps.
